// File: rtl/coin_accumulator.sv
// Coin front-end for the vending machine: validates coins, keeps a running total, locks/refunds.
// Optional inactivity auto-refund is built when COIN_TIMEOUT_EN is defined.
module coin_accumulator #(
  parameter int MAX_TOTAL      = 100,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [2:0] coin_type,
  input  logic       lock,
  // "release" is a reserved word in SystemVerilog, hence the suffix
  input  logic       release_done,
  input  logic       cancel,
  output logic [6:0] total_coin_value,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [6:0] refund_amount,
  output logic [1:0] acc_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_LOCK   = 2'd2,
    S_REFUND = 2'd3
  } state_t;

  // Bad parameter sets leave a marker block in the elaborated hierarchy.
  if (MAX_TOTAL > 127 || (2 ** TMR_W) < TIMEOUT_CYCLES) begin : g_bad_params
  end

  state_t     state_q, state_d;
  logic [6:0] total_q, total_d;
  logic       accept_q, accept_d;
  logic       reject_q, reject_d;
  logic       refund_valid_q, refund_valid_d;
  logic [6:0] refund_amount_q, refund_amount_d;

  logic [5:0] coin_val;
  logic       code_ok;
  logic [7:0] sum;
  logic       coin_ok;

`ifdef COIN_TIMEOUT_EN
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_hit;
`endif

  always_comb begin
    coin_val = 6'd0;
    code_ok  = 1'b1;
    case (coin_type)
      3'd0:    coin_val = 6'd1;
      3'd1:    coin_val = 6'd2;
      3'd2:    coin_val = 6'd5;
      3'd3:    coin_val = 6'd10;
      3'd4:    coin_val = 6'd20;
      3'd5:    coin_val = 6'd50;
      default: code_ok  = 1'b0;
    endcase
    // 8-bit sum so an overflowing coin is caught instead of wrapping
    sum     = {1'b0, total_q} + {2'b00, coin_val};
    coin_ok = coin_valid && code_ok && (sum <= 8'(MAX_TOTAL));
  end

`ifdef COIN_TIMEOUT_EN
  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) &&
                       !coin_valid && !lock && !cancel;
`endif

  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    accept_d        = 1'b0;
    reject_d        = 1'b0;
    refund_valid_d  = 1'b0;
    refund_amount_d = 7'd0;
`ifdef COIN_TIMEOUT_EN
    timer_d         = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          reject_d = coin_valid;
        end else if (lock) begin
          state_d  = S_LOCK;
          reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) begin
            accept_d = 1'b1;
            total_d  = sum[6:0];
            state_d  = S_ACCUM;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (cancel) begin
          state_d         = S_REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = total_q;
          total_d         = 7'd0;
          reject_d        = coin_valid;
        end else if (lock) begin
          state_d  = S_LOCK;
          reject_d = coin_valid;
        end else begin
`ifdef COIN_TIMEOUT_EN
          timer_d = timer_q + 1'b1;
          if (timeout_hit) begin
            state_d         = S_REFUND;
            refund_valid_d  = 1'b1;
            refund_amount_d = total_q;
            total_d         = 7'd0;
          end
`endif
          if (coin_valid) begin
            if (coin_ok) begin
              accept_d = 1'b1;
              total_d  = sum[6:0];
`ifdef COIN_TIMEOUT_EN
              timer_d  = '0;
`endif
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      end
      S_LOCK: begin
        reject_d = coin_valid;
        if (cancel) begin
          state_d         = S_REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = total_q;
          total_d         = 7'd0;
        end else if (release_done) begin
          state_d = S_IDLE;
          total_d = 7'd0;
        end
      end
      default: begin
        // REFUND is a single cycle; total was already cleared on entry
        reject_d = coin_valid;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      total_q         <= 7'd0;
      accept_q        <= 1'b0;
      reject_q        <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= 7'd0;
`ifdef COIN_TIMEOUT_EN
      timer_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      accept_q        <= accept_d;
      reject_q        <= reject_d;
      refund_valid_q  <= refund_valid_d;
      refund_amount_q <= refund_amount_d;
`ifdef COIN_TIMEOUT_EN
      timer_q         <= timer_d;
`endif
    end
  end

  assign total_coin_value = total_q;
  assign coin_accept      = accept_q;
  assign coin_reject      = reject_q;
  assign refund_valid     = refund_valid_q;
  assign refund_amount    = refund_amount_q;
  assign acc_state        = state_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator: hand-computed expectations, immediate-assert checks.
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [2:0] coin_type;
  logic       lock;
  logic       release_done;
  logic       cancel;
  logic [6:0] total_coin_value;
  logic       coin_accept;
  logic       coin_reject;
  logic       refund_valid;
  logic [6:0] refund_amount;
  logic [1:0] acc_state;

  int n_chk = 0;
  int n_err = 0;
  int hit_at;

  coin_accumulator #(.MAX_TOTAL(100), .TIMEOUT_CYCLES(20), .TMR_W(10)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .lock(lock), .release_done(release_done), .cancel(cancel),
    .total_coin_value(total_coin_value), .coin_accept(coin_accept),
    .coin_reject(coin_reject), .refund_valid(refund_valid),
    .refund_amount(refund_amount), .acc_state(acc_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, sample 1 ns later.
  task automatic step(input logic cv, input logic [2:0] ct, input logic lk,
                      input logic rl, input logic cn);
    coin_valid = cv; coin_type = ct; lock = lk; release_done = rl; cancel = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [2:0] ct);
    step(1'b1, ct, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic outs(input string tag, input logic [6:0] tot, input logic acc,
                      input logic rej, input logic rv, input logic [6:0] ra,
                      input logic [1:0] st);
    chk({tag, ".total"}, {1'b0, total_coin_value}, {1'b0, tot});
    chk({tag, ".accept"}, {7'd0, coin_accept}, {7'd0, acc});
    chk({tag, ".reject"}, {7'd0, coin_reject}, {7'd0, rej});
    chk({tag, ".rv"}, {7'd0, refund_valid}, {7'd0, rv});
    chk({tag, ".ra"}, {1'b0, refund_amount}, {1'b0, ra});
    chk({tag, ".state"}, {6'd0, acc_state}, {6'd0, st});
  endtask

  initial begin
    rst = 1'b0;
    idle();
    outs("rst1", 7'd0, 0, 0, 0, 7'd0, 2'd0);
    coin(3'd3);  // a coin during reset must be ignored
    outs("rst2", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    rst = 1'b1;
    coin(3'd3);
    outs("first10", 7'd10, 1, 0, 0, 7'd0, 2'd1);
    idle();
    outs("first10_idle", 7'd10, 0, 0, 0, 7'd0, 2'd1);

    // clear back to zero
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    outs("cancel10", 7'd0, 0, 0, 1, 7'd10, 2'd3);
    idle();
    outs("cancel10_idle", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    coin(3'd5); outs("c50", 7'd50, 1, 0, 0, 7'd0, 2'd1);
    coin(3'd4); outs("c70", 7'd70, 1, 0, 0, 7'd0, 2'd1);
    coin(3'd4); outs("c90", 7'd90, 1, 0, 0, 7'd0, 2'd1);
    coin(3'd3); outs("c100", 7'd100, 1, 0, 0, 7'd0, 2'd1);
    coin(3'd0); outs("over_max", 7'd100, 0, 1, 0, 7'd0, 2'd1);
    coin(3'd7); outs("bad_code", 7'd100, 0, 1, 0, 7'd0, 2'd1);
    idle();     outs("no_coin", 7'd100, 0, 0, 0, 7'd0, 2'd1);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    outs("refund100", 7'd0, 0, 0, 1, 7'd100, 2'd3);
    idle();

    // lock / release
    coin(3'd4); coin(3'd3);
    outs("t30", 7'd30, 1, 0, 0, 7'd0, 2'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    outs("lock30", 7'd30, 0, 0, 0, 7'd0, 2'd2);
    coin(3'd2);
    outs("lock_coin", 7'd30, 0, 1, 0, 7'd0, 2'd2);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    outs("release", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    // cancel together with a coin
    coin(3'd4); coin(3'd2);
    outs("t25", 7'd25, 1, 0, 0, 7'd0, 2'd1);
    step(1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
    outs("cancel25", 7'd0, 0, 1, 1, 7'd25, 2'd3);
    idle();
    outs("after_refund", 7'd0, 0, 0, 0, 7'd0, 2'd0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    outs("cancel_idle", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    // lock in IDLE with zero total
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    outs("lock_idle", 7'd0, 0, 0, 0, 7'd0, 2'd2);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    outs("rel_idle", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    // inactivity
    coin(3'd2);
    outs("t5", 7'd5, 1, 0, 0, 7'd0, 2'd1);
    hit_at = 0;
    for (int k = 1; k <= 100; k++) begin
      idle();
      if (refund_valid === 1'b1 && hit_at == 0) begin
        hit_at = k;
        chk("timeout_amt", {1'b0, refund_amount}, 8'd5);
      end
    end
`ifdef COIN_TIMEOUT_EN
    chk("timeout_cycle", 8'(hit_at), 8'd20);
    chk("timeout_state", {6'd0, acc_state}, 8'd0);
`else
    chk("no_timeout", 8'(hit_at), 8'd0);
    chk("still_accum", {6'd0, acc_state}, 8'd1);
    chk("still_total", {1'b0, total_coin_value}, 8'd5);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    outs("refund5", 7'd0, 0, 0, 1, 7'd5, 2'd3);
    idle();
`endif

    // reset in LOCK, with a cancel pending that must be dropped
    coin(3'd4); coin(3'd4);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    outs("lock40", 7'd40, 0, 0, 0, 7'd0, 2'd2);
    rst = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    outs("rst_lock", 7'd0, 0, 0, 0, 7'd0, 2'd0);
    rst = 1'b1;
    idle();
    outs("post_rst", 7'd0, 0, 0, 0, 7'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
